eth_frame_tx: RTL and testbench

Parametrised Ethernet frame transmitter; successor to the fixed-length MII sender. Reads frame bytes (dest MAC..payload) from a synchronous-read frame RAM and serialises them onto a 2/4/8-bit MII-family TX bus. Generates the 7-byte preamble and the SFD, zero-pads runts to 60 bytes, then appends a CRC-32 FCS and enforces the inter-frame gap. Sits between the camera-frame packetiser RAM and the PHY TX pins. Frame length is set at run time per frame, and start/busy/done handshaking is provided.

---
 rtl/eth_pkg.sv | 11 +
 rtl/eth_crc32.sv | 15 +
 rtl/eth_frame_tx.sv | 162 ++++++++++++++++
 tb/tb_eth_frame_tx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// eth_pkg: Ethernet TX constants and transmitter state type
package eth_pkg;
  localparam logic [7:0] ETH_PREAMBLE = 8'h55;
  localparam logic [7:0] ETH_SFD = 8'hD5;
  localparam logic [31:0] ETH_CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] ETH_CRC_INIT = 32'hFFFFFFFF;
  localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB20E3;
  localparam int ETH_MIN_LEN = 60;
  localparam int ETH_PRE_LEN = 7;
  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, IFG} eth_tx_state_t;
endpackage

// File: rtl/eth_crc32.sv
// eth_crc32: reflected CRC-32 advanced over W input bits, LSB first (crc_in, d -> crc_out)
module eth_crc32
  import eth_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [31:0]  crc_in,
  input  logic [W-1:0] d,
  output logic [31:0]  crc_out
);
  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < W; i++) crc_out = (crc_out >> 1) ^ ((crc_out[0] ^ d[i]) ? ETH_CRC_POLY : 32'h0);
  end
endmodule

// File: rtl/eth_frame_tx.sv
// eth_frame_tx: frame RAM to MII-family serialiser with preamble, padding, FCS and IFG (start/frame_len in, mem_addr/mem_data RAM port, tx_data/tx_en PHY out, busy/done status)
module eth_frame_tx
  import eth_pkg::*;
#(
  parameter int TX_W = 4,
  parameter int ADDR_W = 11,
  parameter int MAX_LEN = 1514,
  parameter int IFG_BYTES = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] frame_len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic [TX_W-1:0]   tx_data,
  output logic              tx_en
);
  localparam int CPB = 8 / TX_W;
  localparam int PW = CPB > 1 ? $clog2(CPB) : 1;
  localparam int CW = ADDR_W + 1;
  localparam logic [PW-1:0] PH_LAST = PW'(CPB - 1);
  localparam logic [CW-1:0] LEAD = CPB == 1 ? CW'(1) : CW'(0);
  localparam logic [CW-1:0] MAX_L = CW'(MAX_LEN);
  localparam logic [CW-1:0] MIN_L = CW'(ETH_MIN_LEN);
  localparam logic [CW-1:0] PRE_LAST = CW'(ETH_PRE_LEN - 1);
  localparam logic [CW-1:0] IFG_LAST = CW'(IFG_BYTES * CPB - 2);
  eth_tx_state_t state_q, state_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [CW-1:0] cnt_q, cnt_d, len_q, len_d, pad_q, pad_d, len_in;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0] sh_q, sh_d;
  logic [31:0] crc_q, crc_d, crc_nx;
  logic done_q, done_d, last;
  function automatic logic [ADDR_W-1:0] cap(input logic [CW-1:0] t, input logic [CW-1:0] l);
    return ADDR_W'(t > l ? l : t);
  endfunction
  eth_crc32 #(.W(TX_W)) u_crc (.crc_in(crc_q), .d(sh_q[TX_W-1:0]), .crc_out(crc_nx));
  assign last = ph_q == PH_LAST;
  assign len_in = {1'b0, frame_len} > MAX_L ? MAX_L : {1'b0, frame_len};
  assign tx_en = state_q inside {PRE, SFD, DATA, PAD, FCS};
  assign tx_data = tx_en ? sh_q[TX_W-1:0] : '0;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign mem_addr = addr_q;
  // The RAM address for byte k+1 is issued on entry to byte k; at one cycle
  // per byte it is issued one byte earlier so read latency still fits.
  // The IFG state is one cycle short because the done/accept cycle is idle too.
  always_comb begin
    state_d = state_q;
    ph_d = last ? '0 : ph_q + 1'b1;
    cnt_d = cnt_q;
    len_d = len_q;
    pad_d = pad_q;
    addr_d = addr_q;
    sh_d = sh_q >> TX_W;
    crc_d = crc_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        ph_d = '0;
        if (start && frame_len != '0) begin
          state_d = PRE;
          len_d = len_in;
          pad_d = len_in < MIN_L ? MIN_L : len_in;
          sh_d = ETH_PREAMBLE;
          cnt_d = '0;
        end
      end
      PRE: if (last) begin
        sh_d = ETH_PREAMBLE;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == PRE_LAST) begin
          state_d = SFD;
          sh_d = ETH_SFD;
          cnt_d = '0;
          addr_d = ADDR_W'(LEAD);
        end
      end
      SFD: begin
        crc_d = ETH_CRC_INIT;
        if (last) begin
          state_d = DATA;
          sh_d = mem_data;
          cnt_d = '0;
          addr_d = cap(CW'(1) + LEAD, len_q);
        end
      end
      DATA: begin
        crc_d = crc_nx;
        if (last) begin
          if (cnt_q == len_q - 1'b1) begin
            state_d = len_q == pad_q ? FCS : PAD;
            sh_d = len_q == pad_q ? ~crc_nx[7:0] : 8'h00;
            cnt_d = len_q == pad_q ? '0 : len_q;
          end else begin
            sh_d = mem_data;
            cnt_d = cnt_q + 1'b1;
            addr_d = cap(cnt_q + CW'(2) + LEAD, len_q);
          end
        end
      end
      PAD: begin
        crc_d = crc_nx;
        if (last) begin
          sh_d = 8'h00;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == pad_q - 1'b1) begin
            state_d = FCS;
            sh_d = ~crc_nx[7:0];
            cnt_d = '0;
          end
        end
      end
      FCS: if (last) begin
        sh_d = 8'(~crc_q >> {cnt_q[1:0] + 2'd1, 3'b000});
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(3)) begin
          state_d = IFG;
          sh_d = 8'h00;
          cnt_d = '0;
        end
      end
      IFG: begin
        ph_d = '0;
        sh_d = 8'h00;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IFG_LAST) begin
          state_d = IDLE;
          done_d = 1'b1;
          addr_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ph_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      pad_q <= '0;
      addr_q <= '0;
      sh_q <= '0;
      crc_q <= ETH_CRC_INIT;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q <= ph_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      pad_q <= pad_d;
      addr_q <= addr_d;
      sh_q <= sh_d;
      crc_q <= crc_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_eth_frame_tx.sv
// tb_eth_frame_tx: table-driven and directed checks of eth_frame_tx at TX_W 4, 2 and 8
module tb_eth_frame_tx;
  localparam int LIM = 20000;
  typedef struct {
    int sel;
    int len;
    int en;
    int dl;
    int gap;
  } vec_t;
  logic clk, rst;
  logic [10:0] frame_len;
  logic start4, start2, start8;
  logic busy4, busy2, busy8, done4, done2, done8, en4, en2, en8;
  logic [10:0] addr4, addr2, addr8;
  logic [7:0] md4, md2, md8, txd8;
  logic [3:0] txd4;
  logic [1:0] txd2;
  logic [7:0] ram [2048];
  int sel, checks, errors, en_cnt, gap, maxa;
  logic done_busy;
  logic [7:0] rx[$], ch[$], md[$];
  logic en_s, busy_s, done_s;
  logic [7:0] txd_s, md_s;
  logic [10:0] addr_s;
  vec_t tv[8];
  eth_frame_tx #(.TX_W(4)) u4 (.clk(clk), .rst(rst), .start(start4), .frame_len(frame_len), .busy(busy4), .done(done4),
    .mem_addr(addr4), .mem_data(md4), .tx_data(txd4), .tx_en(en4));
  eth_frame_tx #(.TX_W(2)) u2 (.clk(clk), .rst(rst), .start(start2), .frame_len(frame_len), .busy(busy2), .done(done2),
    .mem_addr(addr2), .mem_data(md2), .tx_data(txd2), .tx_en(en2));
  eth_frame_tx #(.TX_W(8)) u8 (.clk(clk), .rst(rst), .start(start8), .frame_len(frame_len), .busy(busy8), .done(done8),
    .mem_addr(addr8), .mem_data(md8), .tx_data(txd8), .tx_en(en8));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    md4 <= ram[addr4];
    md2 <= ram[addr2];
    md8 <= ram[addr8];
  end
  assign en_s = sel == 0 ? en4 : sel == 1 ? en2 : en8;
  assign busy_s = sel == 0 ? busy4 : sel == 1 ? busy2 : busy8;
  assign done_s = sel == 0 ? done4 : sel == 1 ? done2 : done8;
  assign txd_s = sel == 0 ? {4'h0, txd4} : sel == 1 ? {6'h0, txd2} : txd8;
  assign md_s = sel == 0 ? md4 : sel == 1 ? md2 : md8;
  assign addr_s = sel == 0 ? addr4 : sel == 1 ? addr2 : addr8;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    for (int i = 0; i < 8; i++) c = (c[0] ^ b[i]) ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    return c;
  endfunction
  task automatic run(input int s, input int len);
    int w, bp, n;
    logic [7:0] cur;
    sel = s;
    w = s == 0 ? 4 : s == 1 ? 2 : 8;
    rx.delete();
    ch.delete();
    md.delete();
    en_cnt = 0;
    gap = 0;
    maxa = 0;
    cur = 8'h00;
    bp = 0;
    n = 0;
    @(negedge clk);
    frame_len = 11'(len);
    start4 = s == 0;
    start2 = s == 1;
    start8 = s == 2;
    @(negedge clk);
    {start4, start2, start8} = 3'b000;
    while (en_s && n < LIM) begin
      ch.push_back(txd_s);
      md.push_back(md_s);
      cur = cur | 8'(txd_s << bp);
      bp += w;
      if (bp == 8) begin
        rx.push_back(cur);
        cur = 8'h00;
        bp = 0;
      end
      if (int'(addr_s) > maxa) maxa = int'(addr_s);
      en_cnt++;
      n++;
      @(negedge clk);
    end
    while (!done_s && n < LIM) begin
      if (int'(addr_s) > maxa) maxa = int'(addr_s);
      gap++;
      n++;
      @(negedge clk);
    end
    done_busy = busy_s;
    if (n >= LIM) chk("timeout", 1, 0);
  endtask
  initial begin
    int p, bad, run_len, g, n;
    logic [31:0] c, r;
    logic [7:0] e;
    tv[0] = '{0, 70, 164, 70, 24};
    tv[1] = '{0, 20, 144, 20, 24};
    tv[2] = '{1, 70, 328, 70, 48};
    tv[3] = '{2, 70, 82, 70, 12};
    tv[4] = '{0, 60, 144, 60, 24};
    tv[5] = '{0, 59, 144, 59, 24};
    tv[6] = '{2, 1, 72, 1, 12};
    tv[7] = '{2, 1614, 1526, 1514, 12};
    for (int i = 0; i < 2048; i++) ram[i] = 8'(i);
    checks = 0;
    errors = 0;
    sel = 0;
    rst = 1'b1;
    frame_len = '0;
    {start4, start2, start8} = 3'b000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tx_en", en4, 0);
    chk("rst_tx_data", txd4, 0);
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_mem_addr", addr4, 0);
    frame_len = 11'd70;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    chk("accept_busy", busy4, 1);
    repeat (76) @(negedge clk);
    chk("byte30_nibble", txd4, 4'hE);
    chk("byte30_addr", addr4, 31);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_tx_en", en4, 0);
    chk("abort_busy", busy4, 0);
    chk("abort_mem_addr", addr4, 0);
    for (int t = 0; t < 8; t++) begin
      run(tv[t].sel, tv[t].len);
      p = tv[t].dl < 60 ? 60 : tv[t].dl;
      chk("tx_en_cycles", en_cnt, tv[t].en);
      chk("byte_count", rx.size(), 8 + p + 4);
      bad = 0;
      for (int i = 0; i < 8; i++) if (rx[i] !== (i == 7 ? 8'hD5 : 8'h55)) bad++;
      chk("preamble_sfd", bad, 0);
      bad = 0;
      for (int i = 0; i < p; i++) begin
        e = i < tv[t].dl ? 8'(i) : 8'h00;
        if (rx[8 + i] !== e) bad++;
      end
      chk("data_pad", bad, 0);
      c = 32'hFFFFFFFF;
      for (int i = 0; i < p; i++) c = crc_byte(c, i < tv[t].dl ? 8'(i) : 8'h00);
      chk("fcs", {rx[8 + p + 3], rx[8 + p + 2], rx[8 + p + 1], rx[8 + p]}, ~c);
      r = 32'hFFFFFFFF;
      for (int i = 8; i < 8 + p + 4; i++) r = crc_byte(r, rx[i]);
      chk("residue", r, 32'hDEBB20E3);
      chk("ifg_to_done", gap + 1, tv[t].gap);
      chk("done_busy", done_busy, 0);
      chk("addr_max", maxa, tv[t].dl);
      if (tv[t].sel == 0) begin
        bad = 0;
        for (int i = 0; i < 20; i++) begin
          e = i < 15 ? 8'h5 : i == 15 ? 8'hD : i == 18 ? 8'h1 : 8'h0;
          if (ch[i] !== e) bad++;
        end
        chk("nibbles", bad, 0);
      end
      if (tv[t].sel == 1) chk("sfd_dibits", {ch[31][1:0], ch[30][1:0], ch[29][1:0], ch[28][1:0]}, 8'b11_01_01_01);
      if (tv[t].sel == 2) begin
        bad = 0;
        for (int i = 8; i < 8 + tv[t].dl; i++) if (ch[i] !== md[i - 1]) bad++;
        chk("capture_to_tx", bad, 0);
      end
    end
    sel = 0;
    n = 0;
    @(negedge clk);
    frame_len = 11'd64;
    start4 = 1'b1;
    while (!en4 && n < 100) begin
      n++;
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      run_len = 0;
      while (en4 && n < LIM) begin
        run_len++;
        n++;
        @(negedge clk);
      end
      chk("b2b_run", run_len, 152);
      if (k < 2) begin
        g = 0;
        while (!en4 && n < LIM) begin
          g++;
          n++;
          @(negedge clk);
        end
        chk("b2b_gap", g, 24);
      end
    end
    start4 = 1'b0;
    while (busy4 && n < LIM) begin
      n++;
      @(negedge clk);
    end
    if (n >= LIM) chk("b2b_timeout", 1, 0);
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    run_len = 0;
    n = 0;
    while (en4 && n < LIM) begin
      if (run_len == 40) begin
        start4 = 1'b1;
        frame_len = 11'd10;
      end
      if (run_len == 41) start4 = 1'b0;
      run_len++;
      n++;
      @(negedge clk);
    end
    chk("midstart_run", run_len, 152);
    while (!done4 && n < LIM) begin
      n++;
      @(negedge clk);
    end
    g = 0;
    repeat (10) begin
      @(negedge clk);
      g += int'(en4) + int'(busy4);
    end
    chk("midstart_no_retx", g, 0);
    frame_len = 11'd0;
    start4 = 1'b1;
    g = 0;
    repeat (6) begin
      @(negedge clk);
      g += int'(en4) + int'(busy4);
    end
    start4 = 1'b0;
    chk("zero_len_ignored", g, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
